// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt controller: latches request edges, raises a single
// non-nesting request to the decoder and tracks the source being serviced.
module irq_ctrl #(
   parameter int NSRC = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] irq_in,
   input  logic            mask_we,
   input  logic [NSRC-1:0] mask_wdata,
   input  logic            ivec_we,
   input  logic [15:0]     ivec_wdata,
   input  logic [3:0]      dec_state,
   input  logic            reti,
   output logic            irq_r,
   output logic            in_service,
   output logic [1:0]      active_src,
   output logic [15:0]     vec_addr,
   output logic [NSRC-1:0] pending,
   output logic [NSRC-1:0] mask
);

   typedef enum logic [1:0] {IDLE, REQ, INSVC} state_t;

   state_t          state_q, state_d;
   logic            irq_r_q, irq_r_d;
   logic            in_service_q, in_service_d;
   logic [1:0]      active_src_q, active_src_d;
   logic [NSRC-1:0] pending_q, pending_d;
   logic [NSRC-1:0] mask_q, mask_d;
   logic [NSRC-1:0] prev_q, prev_d;
   logic [15:0]     ivec_q, ivec_d;

   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] pm;
   logic [NSRC-1:0] clr;
   logic [1:0]      src;

   // Decisions use registered mask/pending only, so writes act a cycle later.
   assign rise = irq_in & ~prev_q;
   assign pm   = pending_q & mask_q;

   always_comb begin
      src = 2'd0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (pm[i]) src = 2'(i);
      end
   end

   always_comb begin
      state_d      = state_q;
      irq_r_d      = irq_r_q;
      in_service_d = in_service_q;
      active_src_d = active_src_q;
      clr          = '0;
      unique case (state_q)
         IDLE: begin
            if (pm != '0) begin
               state_d = REQ;
               irq_r_d = 1'b1;
            end
         end
         REQ: begin
            if (pm == '0) begin
               state_d = IDLE;
               irq_r_d = 1'b0;
            end else if (dec_state == 4'd0) begin
               clr[src]     = 1'b1;
               active_src_d = src;
               in_service_d = 1'b1;
               irq_r_d      = 1'b0;
               state_d      = INSVC;
            end
         end
         INSVC: begin
            if (reti) begin
               state_d      = IDLE;
               in_service_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            irq_r_d = 1'b0;
         end
      endcase
   end

   // A fresh edge on the bit being acknowledged keeps it pending.
   assign pending_d = (pending_q & ~clr) | rise;
   assign prev_d    = irq_in;
   assign mask_d    = mask_we ? mask_wdata : mask_q;
   assign ivec_d    = ivec_we ? ivec_wdata : ivec_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         irq_r_q      <= 1'b0;
         in_service_q <= 1'b0;
         active_src_q <= 2'd0;
         pending_q    <= '0;
         mask_q       <= '0;
         prev_q       <= '0;
         ivec_q       <= 16'd0;
      end else begin
         state_q      <= state_d;
         irq_r_q      <= irq_r_d;
         in_service_q <= in_service_d;
         active_src_q <= active_src_d;
         pending_q    <= pending_d;
         mask_q       <= mask_d;
         prev_q       <= prev_d;
         ivec_q       <= ivec_d;
      end
   end

   assign irq_r      = irq_r_q;
   assign in_service = in_service_q;
   assign active_src = active_src_q;
   assign pending    = pending_q;
   assign mask       = mask_q;
   assign vec_addr   = ivec_q + {12'b0, active_src_q, 2'b00};

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: each scenario task drives vectors and checks
// outputs 1 time unit after the rising edge against hand-computed values.
module tb_irq_ctrl;

   logic        clk;
   logic        reset;
   logic [3:0]  irq_in;
   logic        mask_we;
   logic [3:0]  mask_wdata;
   logic        ivec_we;
   logic [15:0] ivec_wdata;
   logic [3:0]  dec_state;
   logic        reti;
   logic        irq_r;
   logic        in_service;
   logic [1:0]  active_src;
   logic [15:0] vec_addr;
   logic [3:0]  pending;
   logic [3:0]  mask;

   int n_checks = 0;
   int n_fail   = 0;

   irq_ctrl #(.NSRC(4)) dut (
      .clk(clk), .reset(reset), .irq_in(irq_in),
      .mask_we(mask_we), .mask_wdata(mask_wdata),
      .ivec_we(ivec_we), .ivec_wdata(ivec_wdata),
      .dec_state(dec_state), .reti(reti),
      .irq_r(irq_r), .in_service(in_service), .active_src(active_src),
      .vec_addr(vec_addr), .pending(pending), .mask(mask)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step(2);
      reset = 1'b1;
   endtask

   task automatic wr_mask(input logic [3:0] v);
      mask_we = 1'b1; mask_wdata = v;
      step();
      mask_we = 1'b0;
   endtask

   task automatic wr_ivec(input logic [15:0] v);
      ivec_we = 1'b1; ivec_wdata = v;
      step();
      ivec_we = 1'b0;
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      #1;
      n_checks++; if (irq_r !== 1'b0) begin n_fail++; $display("FAIL rst_irq_r got=%b exp=0", irq_r); end
      n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL rst_insvc got=%b exp=0", in_service); end
      n_checks++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL rst_pending got=%b exp=0000", pending); end
      n_checks++; if (mask !== 4'b0000) begin n_fail++; $display("FAIL rst_mask got=%b exp=0000", mask); end
      n_checks++; if (vec_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_vec got=%h exp=0000", vec_addr); end
      step(2);
      reset = 1'b1;
   endtask

   task automatic test_basic();
      do_reset();
      wr_mask(4'b0100);
      wr_ivec(16'h0100);
      irq_in = 4'b0100;
      step();
      n_checks++; if (pending !== 4'b0100) begin n_fail++; $display("FAIL basic_pending got=%b exp=0100", pending); end
      n_checks++; if (irq_r !== 1'b0) begin n_fail++; $display("FAIL basic_irq_early got=%b exp=0", irq_r); end
      irq_in = 4'b0000;
      step();
      n_checks++; if (irq_r !== 1'b1) begin n_fail++; $display("FAIL basic_irq got=%b exp=1", irq_r); end
      dec_state = 4'd0;
      step();
      dec_state = 4'hF;
      n_checks++; if (active_src !== 2'd2) begin n_fail++; $display("FAIL basic_src got=%0d exp=2", active_src); end
      n_checks++; if (vec_addr !== 16'h0108) begin n_fail++; $display("FAIL basic_vec got=%h exp=0108", vec_addr); end
      n_checks++; if (irq_r !== 1'b0) begin n_fail++; $display("FAIL basic_irq_ack got=%b exp=0", irq_r); end
      n_checks++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL basic_pend_ack got=%b exp=0000", pending); end
      n_checks++; if (in_service !== 1'b1) begin n_fail++; $display("FAIL basic_insvc got=%b exp=1", in_service); end
      reti = 1'b1;
      step();
      reti = 1'b0;
      n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL basic_reti got=%b exp=0", in_service); end
      n_checks++; if (active_src !== 2'd2) begin n_fail++; $display("FAIL basic_src_hold got=%0d exp=2", active_src); end
   endtask

   task automatic test_priority();
      do_reset();
      wr_mask(4'b1111);
      irq_in = 4'b1010;
      step();
      irq_in = 4'b0000;
      n_checks++; if (pending !== 4'b1010) begin n_fail++; $display("FAIL prio_pending got=%b exp=1010", pending); end
      step();
      dec_state = 4'd0;
      step();
      dec_state = 4'hF;
      n_checks++; if (active_src !== 2'd1) begin n_fail++; $display("FAIL prio_src1 got=%0d exp=1", active_src); end
      n_checks++; if (pending !== 4'b1000) begin n_fail++; $display("FAIL prio_pend1 got=%b exp=1000", pending); end
      step();
      n_checks++; if (irq_r !== 1'b0) begin n_fail++; $display("FAIL prio_nonest got=%b exp=0", irq_r); end
      reti = 1'b1;
      step();
      reti = 1'b0;
      n_checks++; if (irq_r !== 1'b0) begin n_fail++; $display("FAIL prio_idle_gap got=%b exp=0", irq_r); end
      step();
      n_checks++; if (irq_r !== 1'b1) begin n_fail++; $display("FAIL prio_rereq got=%b exp=1", irq_r); end
      dec_state = 4'd0;
      step();
      dec_state = 4'hF;
      n_checks++; if (active_src !== 2'd3) begin n_fail++; $display("FAIL prio_src3 got=%0d exp=3", active_src); end
      n_checks++; if (vec_addr !== 16'h000C) begin n_fail++; $display("FAIL prio_vec got=%h exp=000c", vec_addr); end
      reti = 1'b1;
      step();
      reti = 1'b0;
   endtask

   task automatic test_mask_withdraw();
      do_reset();
      irq_in = 4'b0001;
      step();
      irq_in = 4'b0000;
      step(2);
      n_checks++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL mask_pending got=%b exp=0001", pending); end
      n_checks++; if (irq_r !== 1'b0) begin n_fail++; $display("FAIL mask_blocked got=%b exp=0", irq_r); end
      wr_mask(4'b0001);
      n_checks++; if (irq_r !== 1'b0) begin n_fail++; $display("FAIL mask_wr_lat got=%b exp=0", irq_r); end
      step();
      n_checks++; if (irq_r !== 1'b1) begin n_fail++; $display("FAIL mask_enable got=%b exp=1", irq_r); end
      // reti while requesting is ignored
      reti = 1'b1;
      step();
      reti = 1'b0;
      n_checks++; if (irq_r !== 1'b1) begin n_fail++; $display("FAIL req_reti_ign got=%b exp=1", irq_r); end
      wr_mask(4'b0000);
      n_checks++; if (irq_r !== 1'b1) begin n_fail++; $display("FAIL wd_lat got=%b exp=1", irq_r); end
      step();
      n_checks++; if (irq_r !== 1'b0) begin n_fail++; $display("FAIL wd_irq got=%b exp=0", irq_r); end
      n_checks++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL wd_pending got=%b exp=0001", pending); end
      dec_state = 4'd0;
      step();
      dec_state = 4'hF;
      n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL idle_ack_ign got=%b exp=0", in_service); end
      n_checks++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL idle_ack_pend got=%b exp=0001", pending); end
   endtask

   task automatic test_wrap_setwins_async();
      do_reset();
      wr_mask(4'b1111);
      wr_ivec(16'hFFFC);
      irq_in = 4'b0010;
      step();
      irq_in = 4'b0000;
      step();
      dec_state = 4'd0;
      step();
      dec_state = 4'hF;
      n_checks++; if (active_src !== 2'd1) begin n_fail++; $display("FAIL wrap_src got=%0d exp=1", active_src); end
      n_checks++; if (vec_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_vec got=%h exp=0000", vec_addr); end
      irq_in = 4'b0001;
      step();
      irq_in = 4'b0000;
      step(2);
      n_checks++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL insvc_accum got=%b exp=0001", pending); end
      n_checks++; if (irq_r !== 1'b0) begin n_fail++; $display("FAIL insvc_noirq got=%b exp=0", irq_r); end
      reti = 1'b1;
      step();
      reti = 1'b0;
      step();
      n_checks++; if (irq_r !== 1'b1) begin n_fail++; $display("FAIL post_reti_irq got=%b exp=1", irq_r); end
      // new edge on bit 0 coincides with its acknowledge
      irq_in = 4'b0001;
      dec_state = 4'd0;
      step();
      dec_state = 4'hF;
      n_checks++; if (active_src !== 2'd0) begin n_fail++; $display("FAIL setwin_src got=%0d exp=0", active_src); end
      n_checks++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL setwin_pend got=%b exp=0001", pending); end
      n_checks++; if (vec_addr !== 16'hFFFC) begin n_fail++; $display("FAIL setwin_vec got=%h exp=fffc", vec_addr); end
      #2 reset = 1'b0;
      #1;
      n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL async_insvc got=%b exp=0", in_service); end
      n_checks++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL async_pend got=%b exp=0000", pending); end
      n_checks++; if (mask !== 4'b0000) begin n_fail++; $display("FAIL async_mask got=%b exp=0000", mask); end
      step();
      reset = 1'b1;
      // irq_in[0] still high across release counts as a new edge
      step();
      n_checks++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL rel_edge got=%b exp=0001", pending); end
      wr_mask(4'b0001);
      step();
      dec_state = 4'd0;
      step();
      dec_state = 4'hF;
      step(2);
      n_checks++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL level_held got=%b exp=0000", pending); end
      irq_in = 4'b0000;
      step();
      irq_in = 4'b0001;
      step();
      n_checks++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL re_rise got=%b exp=0001", pending); end
   endtask

   initial begin
      reset = 1'b1; irq_in = 4'b0; mask_we = 1'b0; mask_wdata = 4'b0;
      ivec_we = 1'b0; ivec_wdata = 16'h0; dec_state = 4'hF; reti = 1'b0;
      test_reset();
      test_basic();
      test_priority();
      test_mask_withdraw();
      test_wrap_setwins_async();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NSRC, default 4, number of interrupt request sources; only 4 SHALL be supported.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous active-low reset; 0 SHALL reset all state immediately.
REQ-004 irq_in  input  4  raw request lines from devices; a rising edge marks a request.
REQ-005 mask_we  input  1  write-enable for the mask register.
REQ-006 mask_wdata  input  4  new mask value; bit i = 1 enables source i.
REQ-007 ivec_we  input  1  write-enable for the vector base register, driven by decoder IVEC_LOAD.
REQ-008 ivec_wdata  input  16  new vector base value.
REQ-009 dec_state  input  4  decoder state; value 0 means the decoder has entered interrupt entry.
REQ-010 reti  input  1  one-cycle return-from-interrupt pulse, driven by decoder RETI.
REQ-011 irq_r  output  1  interrupt request to the decoder.
REQ-012 in_service  output  1  high while a handler is active.
REQ-013 active_src  output  2  index of the source being serviced.
REQ-014 vec_addr  output  16  handler address for active_src.
REQ-015 pending  output  4  latched, unserviced requests.
REQ-016 mask  output  4  current mask register.

Function
REQ-017 Edge detect: a pending[i] set condition SHALL be irq_in[i]=1 with the previous sampled irq_in[i]=0; pending[i] SHALL read 1 from the next cycle.
REQ-018 Level-held inputs SHALL NOT set pending again until they fall and rise again.
REQ-019 FSM states: IDLE, REQ, INSVC.
REQ-020 IDLE -> REQ on the clock edge where (pending & mask) != 0; irq_r SHALL be registered, so it reads 1 in the cycle after that edge.
REQ-021 In REQ, irq_r SHALL stay 1 until an acknowledge or a withdraw occurs.
REQ-022 REQ, dec_state==0: acknowledge; src = lowest index i with pending[i]&mask[i].
REQ-023 On acknowledge, the block SHALL clear pending[src], load active_src=src, set in_service=1, set irq_r=0, and enter INSVC.
REQ-024 REQ, (pending & mask)==0 with no acknowledge, e.g. after a mask write: withdraw; next state IDLE, irq_r=0.
REQ-025 INSVC: no new irq_r SHALL be raised (no nesting); pending bits SHALL continue to accumulate.
REQ-026 INSVC, reti=1: next state IDLE, in_service=0; active_src SHALL hold its last value.
REQ-027 reti in IDLE or REQ SHALL be ignored; dec_state==0 in IDLE or INSVC SHALL be ignored.
REQ-028 vec_addr SHALL be combinational: ivec + {12'b0, active_src, 2'b00}, modulo 2^16 (wrap, no carry out).
REQ-029 mask_we and ivec_we writes SHALL take effect from the next cycle in any state.
REQ-030 Write values SHALL be used for the FSM decision only from the cycle after the write.
REQ-031 Pending set and clear in the same cycle for the same bit: set SHALL win and the bit SHALL stay 1.
REQ-032 INSVC with reti and (pending & mask)!=0 in the same cycle: the block SHALL go to IDLE, then REQ on the following edge (minimum 1 idle cycle).

Reset
REQ-033 While reset=0: state=IDLE, irq_r=0, in_service=0, active_src=0, pending=0, mask=0 (all sources disabled), ivec=0, previous-sample register=0.
REQ-034 Reset asserted mid-REQ or mid-INSVC SHALL abort the sequence with no acknowledge side effects.
REQ-035 After reset release, an irq_in already high SHALL count as a rising edge.

Verification
REQ-036 Reset, mask=4'b0100, ivec=16'h0100, pulse irq_in[2] -> pending=4'b0100; irq_r=1 two edges after the rise; dec_state=0 -> active_src=2, vec_addr=16'h0108, irq_r=0, pending=0.
REQ-037 mask=4'b1111, irq_in[3] and irq_in[1] rise together, acknowledge -> active_src=1, pending=4'b1000; reti -> IDLE, then irq_r=1 again; second acknowledge -> active_src=3.
REQ-038 mask=0, pulse irq_in[0] -> pending=4'b0001, irq_r stays 0; write mask=4'b0001 -> irq_r=1 on the following cycle.
REQ-039 In REQ for source 0, write mask=0 before acknowledge -> irq_r=0 next cycle, state IDLE, pending=4'b0001 retained.
REQ-040 ivec=16'hFFFC, acknowledge source 1 -> vec_addr=16'h0000 (wrap); irq_in[0] rises during INSVC -> no irq_r until reti.
REQ-041 Assert reset during INSVC -> in_service=0, pending=0, mask=0 immediately, without waiting for clk.
